// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner
// encoding and the latched memory command.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_MEM, OWN_IF} arb_owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter; the master modport is everything around it (IF, MEM, memory array).
interface mem_port_arbiter_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [3:0]  i_mem_be;
    logic [31:0] o_if_instr;
    logic        o_if_valid;
    logic [31:0] o_mem_rdata;
    logic        o_mem_valid;
    logic        o_if_stall;
    logic        o_mem_stall;
    logic        o_m_en;
    logic        o_m_we;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic [3:0]  o_m_be;
    logic [31:0] i_m_rdData;

    modport slave (
        input  i_if_req, i_if_addr, i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
               i_mem_be, i_m_rdData,
        output o_if_instr, o_if_valid, o_mem_rdata, o_mem_valid, o_if_stall,
               o_mem_stall, o_m_en, o_m_we, o_m_addr, o_m_wdata, o_m_be
    );

    modport master (
        output i_if_req, i_if_addr, i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
               i_mem_be, i_m_rdData,
        input  o_if_instr, o_if_valid, o_mem_rdata, o_mem_valid, o_if_stall,
               o_mem_stall, o_m_en, o_m_we, o_m_addr, o_m_wdata, o_m_be
    );
endinterface

// File: rtl/mem_arb_prio.sv
// MEM-first winner select with an IF starvation guard: after MAX_IF_WAIT
// consecutive losses IF takes the next tie.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_IF_WAIT = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_if_req,
    input  logic       i_mem_req,
    input  logic       i_idle,
    output arb_owner_t o_owner
);

    logic [3:0] if_wait_cnt;
    logic       mem_wins;

    assign mem_wins = i_mem_req && (!i_if_req || (if_wait_cnt < 4'(MAX_IF_WAIT)));
    assign o_owner  = mem_wins ? OWN_MEM : OWN_IF;

    // Only IDLE cycles are grant opportunities, so only they move the count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            if_wait_cnt <= '0;
        end else if (i_idle) begin
            if (!i_if_req || !mem_wins)
                if_wait_cnt <= '0;
            else if (if_wait_cnt < 4'(MAX_IF_WAIT))
                if_wait_cnt <= if_wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM accesses onto one single-ported memory with a fixed
// read latency; one transaction in flight at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY  = 1,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t  state;
    arb_owner_t  owner;
    arb_owner_t  grant;
    mem_cmd_t    cmd;
    mem_cmd_t    win_cmd;
    logic [2:0]  lat_cnt;
    logic        m_en;
    logic        if_valid;
    logic        mem_valid;
    logic [31:0] if_instr;
    logic [31:0] mem_rdata;
    logic        any_req;

    assign any_req = bus.i_if_req | bus.i_mem_req;

    mem_arb_prio #(.MAX_IF_WAIT(MAX_IF_WAIT)) u_prio (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_if_req  (bus.i_if_req),
        .i_mem_req (bus.i_mem_req),
        .i_idle    (state == IDLE),
        .o_owner   (grant)
    );

    // Fetches are always full-word reads.
    always_comb begin
        win_cmd = '0;
        if (grant == OWN_IF) begin
            win_cmd.we   = 1'b0;
            win_cmd.addr = bus.i_if_addr;
            win_cmd.be   = BE_ALL;
        end else begin
            win_cmd.we    = bus.i_mem_we;
            win_cmd.addr  = bus.i_mem_addr;
            win_cmd.wdata = bus.i_mem_wdata;
            win_cmd.be    = bus.i_mem_be;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            owner     <= OWN_MEM;
            cmd       <= '0;
            lat_cnt   <= '0;
            m_en      <= 1'b0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if_instr  <= '0;
            mem_rdata <= '0;
        end else begin
            m_en      <= 1'b0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= grant;
                        cmd   <= win_cmd;
                        m_en  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cmd.we) begin
                        if_valid  <= (owner == OWN_IF);
                        mem_valid <= (owner == OWN_MEM);
                        state     <= RESP;
                    end else begin
                        lat_cnt <= 3'(RD_LATENCY);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        if (owner == OWN_IF) if_instr  <= bus.i_m_rdData;
                        else                 mem_rdata <= bus.i_m_rdData;
                        if_valid  <= (owner == OWN_IF);
                        mem_valid <= (owner == OWN_MEM);
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_m_en      = m_en;
    assign bus.o_m_we      = cmd.we;
    assign bus.o_m_addr    = cmd.addr;
    assign bus.o_m_wdata   = cmd.wdata;
    assign bus.o_m_be      = cmd.be;
    assign bus.o_if_instr  = if_instr;
    assign bus.o_if_valid  = if_valid;
    assign bus.o_mem_rdata = mem_rdata;
    assign bus.o_mem_valid = mem_valid;
    assign bus.o_if_stall  = bus.i_if_req & ~if_valid;
    assign bus.o_mem_stall = bus.i_mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected
// responses, a negedge monitor checks grants, latency and returned data.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int          RL    = 3;
    localparam int          MW    = 2;
    localparam logic [31:0] DBASE = 32'h0001_0000;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RD_LATENCY(RL), .MAX_IF_WAIT(MW)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory array the DUT talks to; unwritten words read as init_word.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        return mem.exists(k) ? mem[k] : init_word(k);
    endfunction

    logic        s_en, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    int          due = -1;
    logic [31:0] due_data;

    always @(negedge i_clk) begin
        s_en = bus.o_m_en; s_we = bus.o_m_we; s_addr = bus.o_m_addr;
        s_wdata = bus.o_m_wdata; s_be = bus.o_m_be;
    end

    // Read data is present only in the single cycle ending RL edges after the
    // command edge; garbage otherwise, so a wrong capture cycle shows up.
    always @(posedge i_clk) begin
        cyc++;
        if (s_en && i_reset_n) begin
            if (s_we) mem[s_addr & ~32'h3] = merge(mem_rd(s_addr), s_wdata, s_be);
            else begin
                due      = cyc + RL;
                due_data = mem_rd(s_addr);
            end
        end
        #1 bus.i_m_rdData = (due == cyc + 1) ? due_data : $urandom();
    end

    // Reference model: IF region is read-only, MEM data region tracked here in
    // program order.
    typedef struct packed { logic we; logic [31:0] data; } mexp_t;
    logic [31:0] if_q [$];
    mexp_t       mem_q [$];
    logic [31:0] dref [logic [31:0]];
    int          mem_done = 0;

    function automatic logic [31:0] dref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        return dref.exists(k) ? dref[k] : init_word(k);
    endfunction

    task automatic do_if(input logic [31:0] a, output int lat);
        int c0;
        @(posedge i_clk); #1;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = a;
        if_q.push_back(init_word(a & ~32'h3));
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (bus.o_if_valid) begin
                chk("if_stall_at_valid", 32'(bus.o_if_stall), 32'd0);
                lat = cyc - c0;
                break;
            end
            chk("if_stall_wait", 32'(bus.o_if_stall), 32'd1);
        end
        if (lat < 0) fail_now("if_timeout");
        bus.i_if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output int lat);
        int    c0;
        mexp_t e;
        @(posedge i_clk); #1;
        bus.i_mem_req = 1'b1; bus.i_mem_we = we; bus.i_mem_addr = a;
        bus.i_mem_wdata = wd; bus.i_mem_be = be;
        e.we   = we;
        e.data = we ? 32'h0 : dref_rd(a);
        if (we) dref[a & ~32'h3] = merge(dref_rd(a), wd, be);
        mem_q.push_back(e);
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (bus.o_mem_valid) begin
                chk("mem_stall_at_valid", 32'(bus.o_mem_stall), 32'd0);
                lat = cyc - c0;
                break;
            end
            chk("mem_stall_wait", 32'(bus.o_mem_stall), 32'd1);
        end
        if (lat < 0) fail_now("mem_timeout");
        else mem_done++;
        bus.i_mem_req = 1'b0;
    endtask

    // Monitor: arbitration rule, command contents, latency and response data.
    logic       p_if = 1'b0, p_mem = 1'b0;
    int         losses = 0;
    int         en_cyc = 0;
    logic       en_we  = 1'b0;
    arb_owner_t exp_own, got_own;
    mexp_t      mx;

    always @(negedge i_clk) begin
        if (!i_reset_n) losses = 0;
        else begin
            if (bus.o_m_en) begin
                got_own = bus.o_m_addr[16] ? OWN_MEM : OWN_IF;
                exp_own = (p_mem && (!p_if || losses < MW)) ? OWN_MEM : OWN_IF;
                chk("grant_has_req", 32'(p_if | p_mem), 32'd1);
                chk("grant_owner", 32'(got_own), 32'(exp_own));
                if (got_own == OWN_IF) begin
                    losses = 0;
                    chk("if_cmd_addr", bus.o_m_addr, bus.i_if_addr);
                    chk("if_cmd_we_be", {27'd0, bus.o_m_we, bus.o_m_be}, {27'd0, 1'b0, BE_ALL});
                end else begin
                    losses = p_if ? losses + 1 : 0;
                    chk("mem_cmd_addr", bus.o_m_addr, bus.i_mem_addr);
                    chk("mem_cmd_we", 32'(bus.o_m_we), 32'(bus.i_mem_we));
                    if (bus.i_mem_we) begin
                        chk("mem_cmd_wdata", bus.o_m_wdata, bus.i_mem_wdata);
                        chk("mem_cmd_be", 32'(bus.o_m_be), 32'(bus.i_mem_be));
                    end
                end
                en_cyc = cyc;
                en_we  = bus.o_m_we;
            end
            if (bus.o_if_valid || bus.o_mem_valid) begin
                chk("valid_exclusive", 32'(bus.o_if_valid & bus.o_mem_valid), 32'd0);
                chk("resp_latency", cyc - en_cyc, en_we ? 32'd1 : 32'(RL + 1));
            end
            if (bus.o_if_valid) begin
                if (if_q.size() == 0) fail_now("if_valid_unexpected");
                else chk("if_instr", bus.o_if_instr, if_q.pop_front());
            end
            if (bus.o_mem_valid) begin
                if (mem_q.size() == 0) fail_now("mem_valid_unexpected");
                else begin
                    mx = mem_q.pop_front();
                    chk("mem_kind", 32'(en_we), 32'(mx.we));
                    if (!mx.we) chk("mem_rdata", bus.o_mem_rdata, mx.data);
                end
            end
        end
        p_if  = bus.i_if_req;
        p_mem = bus.i_mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int li, lm, n_before;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0;
        bus.i_mem_req = 1'b0; bus.i_mem_we = 1'b0; bus.i_mem_addr = '0;
        bus.i_mem_wdata = '0; bus.i_mem_be = '0;

        repeat (2) @(negedge i_clk);
        chk("rst_m_en_we_be", {27'd0, bus.o_m_en, bus.o_m_we, bus.o_m_be}, 32'd0);
        chk("rst_m_addr", bus.o_m_addr, 32'd0);
        chk("rst_m_wdata", bus.o_m_wdata, 32'd0);
        chk("rst_valids_stalls", {28'd0, bus.o_if_valid, bus.o_mem_valid, bus.o_if_stall,
                                  bus.o_mem_stall}, 32'd0);
        chk("rst_if_instr", bus.o_if_instr, 32'd0);
        chk("rst_mem_rdata", bus.o_mem_rdata, 32'd0);
        i_reset_n = 1'b1;

        do_if(32'h0000_0040, li);
        chk("lone_if_latency", li, RL + 2);

        do_mem(1'b1, DBASE + 32'h100, 32'h1234_5678, 4'b0011, lm);
        chk("lone_store_latency", lm, 32'd2);
        do_mem(1'b0, DBASE + 32'h100, 32'h0, 4'h0, lm);
        chk("load_back_latency", lm, RL + 2);

        // Tie: MEM store first, IF starts in the IDLE after MEM's RESP.
        fork
            do_mem(1'b1, DBASE + 32'h8, 32'hCAFE_F00D, 4'hF, lm);
            do_if(32'h0000_0084, li);
        join
        chk("tie_mem_latency", lm, 32'd2);
        chk("tie_if_latency", li, RL + 5);

        // Starvation: MEM keeps re-requesting; IF gets in after MW losses.
        n_before = -1;
        fork
            repeat (MW + 2) do_mem(1'b0, DBASE + 32'(($urandom_range(0, 15)) * 4), 32'h0, 4'h0, lm);
            begin
                do_if(32'h0000_0200, li);
                n_before = mem_done;
            end
        join
        chk("starve_mem_before_if", n_before - (mem_done - (MW + 2)), MW);

        // Reset during WAIT, request held across it and restarted afterwards.
        fork
            do_if(32'h0000_0300, li);
            begin
                for (int i = 0; i < 20 && !bus.o_m_en; i++) @(negedge i_clk);
                @(negedge i_clk);
                #2 i_reset_n = 1'b0;
                #1;
                chk("midrst_m_en", 32'(bus.o_m_en), 32'd0);
                chk("midrst_m_addr", bus.o_m_addr, 32'd0);
                chk("midrst_valids", {30'd0, bus.o_if_valid, bus.o_mem_valid}, 32'd0);
                repeat (2) @(negedge i_clk);
                #2 i_reset_n = 1'b1;
            end
        join
        chk("midrst_restart_slower", 32'(li > RL + 2), 32'd1);

        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                do_if({20'h0, 10'($urandom()), 2'b00}, li);
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                do_mem(1'($urandom()), DBASE + 32'(($urandom_range(0, 15)) * 4), $urandom(),
                       4'($urandom()), lm);
            end
        join

        repeat (10) @(negedge i_clk);
        chk("if_queue_drained", if_q.size(), 32'd0);
        chk("mem_queue_drained", mem_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sits between the IF/MEM stage logic and the memory array.
- Serialises accesses through a fixed-latency req/valid handshake and applies MEM-first priority with an IF starvation guard.
- Gives a later single-port memory one access at a time and lets the pipeline stall on the stall outputs.

Parameters:
- RD_LATENCY, 1: cycles from the memory command edge until i_m_rdData is valid; legal range 1..7.
- MAX_IF_WAIT, 4: consecutive cycles IF may be denied before IF is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  IF read request; held with i_if_addr until o_if_valid.
- i_if_addr  in  32  IF byte address.
- i_mem_req  in  1  MEM request; held with addr/wdata/we/be until o_mem_valid.
- i_mem_we  in  1  1 = store, 0 = load.
- i_mem_addr  in  32  MEM byte address.
- i_mem_wdata  in  32  store data.
- i_mem_be  in  4  store byte enables.
- o_if_instr  out  32  fetched word; valid with o_if_valid.
- o_if_valid  out  1  one-cycle completion pulse for IF.
- o_mem_rdata  out  32  load word; valid with o_mem_valid.
- o_mem_valid  out  1  one-cycle completion pulse for MEM.
- o_if_stall  out  1  i_if_req & ~o_if_valid.
- o_mem_stall  out  1  i_mem_req & ~o_mem_valid.
- o_m_en  out  1  memory command strobe.
- o_m_we  out  1  memory write enable; only meaningful with o_m_en.
- o_m_addr  out  32  memory address.
- o_m_wdata  out  32  memory write data.
- o_m_be  out  4  memory byte enables.
- i_m_rdData  in  32  memory read data, valid RD_LATENCY cycles after the command edge.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - Asynchronous active-low reset i_reset_n.
  - Reset values: state IDLE; every output register 0, so o_*_valid=0, o_m_en=0, data outputs 0; wait counter 0; owner register = MEM.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Otherwise pick a winner:
    - MEM wins if i_mem_req and (~i_if_req or if_wait_cnt < MAX_IF_WAIT).
    - Else IF wins.
  - At the edge, latch the owner and the winner's addr/wdata/be/we into command registers; go to ACCESS.
  - IF commands are always reads with be = 4'hF.
- ACCESS:
  - o_m_en=1 for exactly this one cycle; o_m_* driven from the command registers.
  - Write: go to RESP.
  - Read: load the latency counter with RD_LATENCY and go to WAIT.
- WAIT:
  - o_m_en=0; counter decrements each cycle.
  - When counter==1: capture i_m_rdData into the owner's response register, go to RESP.
- RESP:
  - The owner's valid is 1 for exactly this cycle; the response data register holds until the next capture.
  - No grant is made in RESP, so the requester drops req in this cycle.
  - Next state IDLE.
- Latency from req seen in IDLE to valid:
  - write: 2 cycles;
  - read: RD_LATENCY+2 cycles.
  - Back-to-back throughput: one transaction per (latency+1) cycles.
- Starvation counter if_wait_cnt (4 bits, saturating at MAX_IF_WAIT):
  - +1 in each IDLE cycle where i_if_req=1 and MEM wins.
  - Cleared when IF is granted or i_if_req=0.
  - Unchanged in ACCESS, WAIT and RESP.
- Simultaneous requests:
  - Default: MEM wins.
  - IF wins after MAX_IF_WAIT consecutive losses; the counter then clears, so MEM wins the next tie.
- Requester drops req mid-transaction: the transaction still completes and valid still pulses; the requester ignores it. No abort.
- Request inputs changing while owned: ignored, because the command registers hold the latched values.
- Reset asserted mid-operation: immediate return to IDLE; o_m_en deasserts asynchronously; any in-flight read is discarded.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Stall outputs are combinational from req and the registered valid.

Decomposition:
- Shared core package holds:
  - arb_state_t enum {IDLE, ACCESS, WAIT, RESP};
  - arb_owner_t enum {OWN_MEM, OWN_IF};
  - localparam BE_ALL = 4'hF.
- One sub-module, mem_arb_prio:
  - Combinational winner select plus the registered saturating if_wait_cnt.
  - Inputs: i_if_req, i_mem_req, idle-cycle qualifier.
  - Output: grant owner.
- The FSM, latency counter and command/response registers live in mem_port_arbiter.

Test Plan:
- Lone IF read: i_if_req=1, addr 0x40, i_m_rdData=0xDEADBEEF at RD_LATENCY=1 -> o_m_en one cycle with o_m_addr=0x40; o_if_valid at cycle 3 with o_if_instr=0xDEADBEEF; o_if_stall high cycles 0-2.
- Lone MEM store: addr 0x100, wdata 0x12345678, be 4'b0011 -> o_m_en=o_m_we=1 with exact values in cycle 1; o_mem_valid in cycle 2; o_if_valid stays 0.
- Tie: both req in the same cycle -> MEM granted first; IF's ACCESS follows in the first IDLE after MEM's RESP; no cycle has both valids set.
- Starvation, MAX_IF_WAIT=2: MEM re-requests continuously, IF held -> IF granted on its third IDLE contention cycle; MEM wins the following tie.
- Latency sweep RD_LATENCY=3: IF read -> o_m_en at cycle 1; data sampled at cycle 4; o_if_valid at cycle 5.
- Reset mid-WAIT: pulse i_reset_n low during WAIT -> all outputs 0 asynchronously, FSM in IDLE; a request held afterwards restarts cleanly with correct data.
